fetch_sequencer: RTL

Timing and fetch controller for the 8-bit CPU datapath. It fetches each 16-bit instruction as two byte reads from memory at PC into IR (low, then high half) and increments PC after each read. It then hands control to the execute controller through a start/done handshake and publishes the timing step `T`. It sits between `CPUSystem`'s control logic and the ALUSystem select lines for IR, ARF(PC) and memory.

---
 rtl/fetch_sequencer.sv | 107 ++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: two-byte instruction fetch and execute handshake timing.
// Ports: Clock/Reset/Run/ExecDone in; ExecStart, T_out, memory, ARF, IR
// select lines, InstrCount and sticky ExecTimeout out (all Moore).
module fetch_sequencer #(
   parameter int MAX_EXEC = 6
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Run,
   input  logic        ExecDone,
   output logic        ExecStart,
   output logic [2:0]  T_out,
   output logic        Mem_CS,
   output logic        Mem_WR,
   output logic [1:0]  ARF_OutBSel,
   output logic [1:0]  ARF_FunSel,
   output logic [3:0]  ARF_RSel,
   output logic        IR_Enable,
   output logic        IR_LH,
   output logic [1:0]  IR_Funsel,
   output logic [15:0] InstrCount,
   output logic        ExecTimeout
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_FETCH_L = 2'd1;
   localparam logic [1:0] S_FETCH_H = 2'd2;
   localparam logic [1:0] S_EXEC    = 2'd3;

   localparam logic [5:0] EC_MAX = 6'(MAX_EXEC);

   logic [1:0]  state, state_nx;
   logic [5:0]  ec, ec_nx;
   logic [15:0] instr_count, instr_count_nx;
   logic        timeout, timeout_nx;
   logic        fetch;

   always_comb begin
      state_nx       = state;
      ec_nx          = ec;
      instr_count_nx = instr_count;
      timeout_nx     = timeout;
      unique case (state)
         S_IDLE: begin
            if (Run && !timeout)
               state_nx = S_FETCH_L;
         end
         S_FETCH_L: state_nx = S_FETCH_H;
         S_FETCH_H: begin
            state_nx = S_EXEC;
            ec_nx    = 6'd1;
         end
         S_EXEC: begin
            // done takes priority over the timeout on the last allowed cycle
            if (ExecDone) begin
               instr_count_nx = instr_count + 16'd1;
               state_nx       = Run ? S_FETCH_L : S_IDLE;
            end else if (ec == EC_MAX) begin
               timeout_nx = 1'b1;
               state_nx   = S_IDLE;
            end else begin
               ec_nx = ec + 6'd1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state       <= S_IDLE;
         ec          <= 6'd0;
         instr_count <= 16'd0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_nx;
         ec          <= ec_nx;
         instr_count <= instr_count_nx;
         timeout     <= timeout_nx;
      end
   end

   assign fetch = (state == S_FETCH_L) || (state == S_FETCH_H);

   // execute steps start at 2 and saturate at 7
   always_comb begin
      T_out = 3'd0;
      unique case (state)
         S_FETCH_H: T_out = 3'd1;
         S_EXEC:    T_out = (ec >= 6'd6) ? 3'd7 : (ec[2:0] + 3'd1);
         default:   T_out = 3'd0;
      endcase
   end

   assign ExecStart   = (state == S_EXEC) && (ec == 6'd1);
   assign Mem_CS      = !fetch;
   assign Mem_WR      = 1'b0;
   assign ARF_OutBSel = 2'b00;
   assign ARF_FunSel  = fetch ? 2'b11 : 2'b01;
   assign ARF_RSel    = fetch ? 4'b1000 : 4'b0000;
   assign IR_Enable   = fetch;
   assign IR_LH       = (state == S_FETCH_H);
   assign IR_Funsel   = 2'b01;
   assign InstrCount  = instr_count;
   assign ExecTimeout = timeout;

endmodule
